// File: rtl/riscv_defines.sv
// Shared EX-stage type definitions: scheduler states, op classes and result-mux selects.
package riscv_defines;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        HOLD     = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        OPC_ALU  = 2'd0,
        OPC_MUL  = 2'd1,
        OPC_DIV  = 2'd2,
        OPC_NONE = 2'd3
    } op_class_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MUL = 2'd1,
        RES_DIV = 2'd2
    } res_sel_t;

    localparam int unsigned SCHED_WAIT_MAX_DEF = 64;
    localparam int unsigned SCHED_CNT_W_DEF    = 7;

    function automatic logic is_wait_state(sched_state_t s);
        return (s == MUL_WAIT) || (s == DIV_WAIT);
    endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Saturating wait counter for outstanding mul/div ops, plus the sticky expiry flag.
module sched_watchdog
    import riscv_defines::*;
#(
    parameter int unsigned WAIT_MAX = SCHED_WAIT_MAX_DEF,
    parameter int unsigned CNT_W    = SCHED_CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    input  logic trip_i,
    output logic at_limit_o,
    output logic wd_error_o
);

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wd_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            wd_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wd_q  <= wd_q | trip_i;
        end
    end

    // The cycle that would count up to WAIT_MAX is the expiry cycle.
    assign at_limit_o = (cnt_q == LIMIT_M1);
    assign wd_error_o = wd_q | trip_i;

endmodule

// File: rtl/ex_unit_sched.sv
// EX-stage sequencer for ALU / multiplier / divider: start pulses, stall, result steering, kill.
// Optional EX_SCHED_PERF_EN adds mul_cycles / div_cycles / stall_cycles counters.
module ex_unit_sched
    import riscv_defines::*;
#(
    parameter int unsigned WAIT_MAX = SCHED_WAIT_MAX_DEF,
    parameter int unsigned CNT_W    = SCHED_CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_fire,
    input  logic        flush_e,
    input  logic        stall_down,
    input  logic [1:0]  op_class,
    input  logic        mul_valid,
    input  logic        div_valid,
    output logic        mul_start,
    output logic        div_start,
    output logic        unit_kill,
    output logic        busy_stall,
    output logic [1:0]  res_sel,
    output logic        res_valid,
    output logic        wd_error
`ifdef EX_SCHED_PERF_EN
    ,
    output logic [31:0] mul_cycles,
    output logic [31:0] div_cycles,
    output logic [31:0] stall_cycles
`endif
);

    sched_state_t state_q, state_d;
    res_sel_t     held_sel_q, held_sel_d;
    res_sel_t     sel;
    op_class_t    op;
    logic         alu_hold_q, alu_hold_d;
    logic         alu_pend, unit_valid;
    logic         wd_clr, wd_inc, wd_trip, wd_at_limit;

    sched_watchdog #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) u_wd (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (wd_clr),
        .inc_i      (wd_inc),
        .trip_i     (wd_trip),
        .at_limit_o (wd_at_limit),
        .wd_error_o (wd_error)
    );

    always_comb begin
        state_d    = state_q;
        held_sel_d = held_sel_q;
        alu_hold_d = 1'b0;
        op         = op_class_t'(op_class);
        sel        = RES_ALU;
        alu_pend   = 1'b0;
        unit_valid = 1'b0;
        mul_start  = 1'b0;
        div_start  = 1'b0;
        unit_kill  = 1'b0;
        busy_stall = 1'b0;
        res_valid  = 1'b0;
        wd_clr     = 1'b0;
        wd_inc     = 1'b0;
        wd_trip    = 1'b0;
        if (rst) begin
            state_d = IDLE;
        end else if (flush_e) begin
            unit_kill = (state_q != IDLE);
            state_d   = IDLE;
            wd_clr    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // An ALU result stalled by MEM1 stays valid until it is accepted.
                    alu_pend = alu_hold_q || (ex_fire && (op == OPC_ALU));
                    if (alu_pend) begin
                        res_valid  = 1'b1;
                        busy_stall = stall_down;
                        alu_hold_d = stall_down;
                    end else if (ex_fire && (op == OPC_MUL)) begin
                        mul_start  = 1'b1;
                        busy_stall = 1'b1;
                        wd_clr     = 1'b1;
                        state_d    = MUL_WAIT;
                    end else if (ex_fire && (op == OPC_DIV)) begin
                        div_start  = 1'b1;
                        busy_stall = 1'b1;
                        wd_clr     = 1'b1;
                        state_d    = DIV_WAIT;
                    end
                end
                MUL_WAIT, DIV_WAIT: begin
                    sel        = (state_q == MUL_WAIT) ? RES_MUL : RES_DIV;
                    unit_valid = (state_q == MUL_WAIT) ? mul_valid : div_valid;
                    wd_inc     = 1'b1;
                    if (unit_valid) begin
                        res_valid  = 1'b1;
                        busy_stall = stall_down;
                        held_sel_d = sel;
                        state_d    = stall_down ? HOLD : IDLE;
                    end else if (wd_at_limit) begin
                        wd_trip   = 1'b1;
                        unit_kill = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        busy_stall = 1'b1;
                    end
                end
                HOLD: begin
                    sel        = held_sel_q;
                    res_valid  = 1'b1;
                    busy_stall = stall_down;
                    if (!stall_down) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign res_sel = sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            held_sel_q <= RES_ALU;
            alu_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_sel_q <= held_sel_d;
            alu_hold_q <= alu_hold_d;
        end
    end

`ifdef EX_SCHED_PERF_EN
    logic [31:0] mul_cycles_q, div_cycles_q, stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cycles_q   <= '0;
            div_cycles_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (state_q == MUL_WAIT) mul_cycles_q <= mul_cycles_q + 32'd1;
            if (state_q == DIV_WAIT) div_cycles_q <= div_cycles_q + 32'd1;
            if (busy_stall)          stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign mul_cycles   = mul_cycles_q;
    assign div_cycles   = div_cycles_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_ex_unit_sched.sv
// Scoreboard bench for ex_unit_sched: stimulus queues expected per-cycle activity, a monitor pops and compares.
module tb_ex_unit_sched;

    logic        clk = 1'b0;
    logic        rst, ex_fire, flush_e, stall_down, mul_valid, div_valid;
    logic [1:0]  op_class;
    logic        mul_start, div_start, unit_kill, busy_stall, res_valid, wd_error;
    logic [1:0]  res_sel;
`ifdef EX_SCHED_PERF_EN
    logic [31:0] mul_cycles, div_cycles, stall_cycles;
`endif

    ex_unit_sched #(.WAIT_MAX(64), .CNT_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_fire    (ex_fire),
        .flush_e    (flush_e),
        .stall_down (stall_down),
        .op_class   (op_class),
        .mul_valid  (mul_valid),
        .div_valid  (div_valid),
        .mul_start  (mul_start),
        .div_start  (div_start),
        .unit_kill  (unit_kill),
        .busy_stall (busy_stall),
        .res_sel    (res_sel),
        .res_valid  (res_valid),
        .wd_error   (wd_error)
`ifdef EX_SCHED_PERF_EN
        ,
        .mul_cycles   (mul_cycles),
        .div_cycles   (div_cycles),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int unsigned cyc;
        logic        rv;
        logic [1:0]  sel;
        logic        bs;
        logic        ms;
        logic        ds;
        logic        uk;
        logic        wd;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic        exp_wd = 1'b0;
    logic        prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any cycle with visible scheduler activity must match the next queued entry.
    always @(negedge clk) begin
        ev_t got, e;
        if (!rst) begin
            n_cmp++;
            if ((mul_start && div_start) || (ex_fire && prev_busy && !flush_e)) begin
                n_bad++;
                $display("FAIL protocol @%0d: mul_start=%b div_start=%b ex_fire=%b prev_busy=%b required no dual start and no fire under stall",
                         cyc, mul_start, div_start, ex_fire, prev_busy);
            end
        end
        if ((res_valid | busy_stall | mul_start | div_start | unit_kill) !== 1'b0) begin
            got = '{cyc: cyc, rv: res_valid, sel: res_sel, bs: busy_stall,
                    ms: mul_start, ds: div_start, uk: unit_kill, wd: wd_error};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected @%0d: got rv=%b sel=%0d bs=%b ms=%b ds=%b uk=%b wd=%b, required no activity",
                         cyc, got.rv, got.sel, got.bs, got.ms, got.ds, got.uk, got.wd);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL trace: got cyc=%0d rv=%b sel=%0d bs=%b ms=%b ds=%b uk=%b wd=%b, required cyc=%0d rv=%b sel=%0d bs=%b ms=%b ds=%b uk=%b wd=%b",
                             got.cyc, got.rv, got.sel, got.bs, got.ms, got.ds, got.uk, got.wd,
                             e.cyc, e.rv, e.sel, e.bs, e.ms, e.ds, e.uk, e.wd);
                end
            end
        end
        prev_busy = (busy_stall === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic rv, input logic [1:0] sel, input logic bs,
                             input logic ms, input logic ds, input logic uk);
        ev_t e;
        e = '{cyc: cyc, rv: rv, sel: sel, bs: bs, ms: ms, ds: ds, uk: uk, wd: exp_wd};
        exp_q.push_back(e);
    endtask

    task automatic chk_zero(input string name);
        logic [7:0] v;
        v = {res_valid, res_sel, busy_stall, mul_start, div_start, unit_kill, wd_error};
        n_cmp++;
        if (v !== 8'h00) begin
            n_bad++;
            $display("FAIL %s: outputs {rv,sel,bs,ms,ds,uk,wd}=%b, required 00000000", name, v);
        end
`ifdef EX_SCHED_PERF_EN
        n_cmp++;
        if ({mul_cycles, div_cycles, stall_cycles} !== 96'd0) begin
            n_bad++;
            $display("FAIL %s_perf: mul=%0d div=%0d stall=%0d, required 0 0 0", name, mul_cycles, div_cycles, stall_cycles);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; ex_fire = 1'b0; flush_e = 1'b0; stall_down = 1'b0;
        op_class = 2'd3; mul_valid = 1'b0; div_valid = 1'b0;
        repeat (3) tick();
        chk_zero("reset_hold");
        rst = 1'b0;
        tick();
        chk_zero("reset_idle");

        // ALU, no stall: result valid in the fire cycle
        ex_fire = 1'b1; op_class = 2'd0; expect_ev(1, 0, 0, 0, 0, 0); tick();
        ex_fire = 1'b0; op_class = 2'd3; tick();

        // ALU with MEM1 stalled for two cycles: result held, stall raised
        ex_fire = 1'b1; op_class = 2'd0; stall_down = 1'b1; expect_ev(1, 0, 1, 0, 0, 0); tick();
        ex_fire = 1'b0; op_class = 2'd3; expect_ev(1, 0, 1, 0, 0, 0); tick();
        stall_down = 1'b0; expect_ev(1, 0, 0, 0, 0, 0); tick();
        tick();

        // MUL, valid 3 cycles after start
        ex_fire = 1'b1; op_class = 2'd1; expect_ev(0, 0, 1, 1, 0, 0); tick();
        ex_fire = 1'b0; op_class = 2'd3;
        for (int i = 0; i < 2; i++) begin expect_ev(0, 1, 1, 0, 0, 0); tick(); end
        mul_valid = 1'b1; expect_ev(1, 1, 0, 0, 0, 0); tick();
        mul_valid = 1'b0;
`ifdef EX_SCHED_PERF_EN
        n_cmp++;
        if (mul_cycles !== 32'd3 || stall_cycles !== 32'd5) begin
            n_bad++;
            $display("FAIL perf_mul: mul=%0d stall=%0d, required 3 5", mul_cycles, stall_cycles);
        end
`endif
        tick();

        // MUL with valid already high in the start cycle: taken one cycle later
        ex_fire = 1'b1; op_class = 2'd1; mul_valid = 1'b1; expect_ev(0, 0, 1, 1, 0, 0); tick();
        ex_fire = 1'b0; op_class = 2'd3; expect_ev(1, 1, 0, 0, 0, 0); tick();
        mul_valid = 1'b0; tick();

        // DIV, valid at cycle 33 with MEM1 stalled through cycle 35
        ex_fire = 1'b1; op_class = 2'd2; expect_ev(0, 0, 1, 0, 1, 0); tick();
        ex_fire = 1'b0; op_class = 2'd3;
        for (int i = 1; i <= 32; i++) begin expect_ev(0, 2, 1, 0, 0, 0); tick(); end
        div_valid = 1'b1; stall_down = 1'b1;
        for (int i = 33; i <= 35; i++) begin expect_ev(1, 2, 1, 0, 0, 0); tick(); end
        stall_down = 1'b0; expect_ev(1, 2, 0, 0, 0, 0); tick();
        div_valid = 1'b0; tick();

        // DIV flushed at cycle 5 with a same-cycle fire that must be ignored, then a normal MUL
        ex_fire = 1'b1; op_class = 2'd2; expect_ev(0, 0, 1, 0, 1, 0); tick();
        ex_fire = 1'b0; op_class = 2'd3;
        for (int i = 1; i <= 4; i++) begin expect_ev(0, 2, 1, 0, 0, 0); tick(); end
        flush_e = 1'b1; ex_fire = 1'b1; op_class = 2'd1; expect_ev(0, 0, 0, 0, 0, 1); tick();
        flush_e = 1'b0; expect_ev(0, 0, 1, 1, 0, 0); tick();
        ex_fire = 1'b0; op_class = 2'd3; mul_valid = 1'b1; expect_ev(1, 1, 0, 0, 0, 0); tick();
        mul_valid = 1'b0; tick();

        // MUL that never completes: watchdog trips at cycle 64
        ex_fire = 1'b1; op_class = 2'd1; expect_ev(0, 0, 1, 1, 0, 0); tick();
        ex_fire = 1'b0; op_class = 2'd3;
        for (int i = 1; i <= 63; i++) begin expect_ev(0, 1, 1, 0, 0, 0); tick(); end
        exp_wd = 1'b1; expect_ev(0, 1, 0, 0, 0, 1); tick();
        repeat (3) tick();
        n_cmp++;
        if (wd_error !== 1'b1) begin
            n_bad++;
            $display("FAIL wd_sticky: wd_error=%b, required 1", wd_error);
        end
        ex_fire = 1'b1; op_class = 2'd1; mul_valid = 1'b1; expect_ev(0, 0, 1, 1, 0, 0); tick();
        ex_fire = 1'b0; op_class = 2'd3; expect_ev(1, 1, 0, 0, 0, 0); tick();
        mul_valid = 1'b0; tick();

        // Reset in the middle of DIV_WAIT: silent drop, no kill
        ex_fire = 1'b1; op_class = 2'd2; expect_ev(0, 0, 1, 0, 1, 0); tick();
        ex_fire = 1'b0; op_class = 2'd3;
        for (int i = 1; i <= 4; i++) begin expect_ev(0, 2, 1, 0, 0, 0); tick(); end
        rst = 1'b1; exp_wd = 1'b0; tick();
        rst = 1'b0;
        chk_zero("reset_mid_div");
        repeat (3) tick();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
